// File: rtl/staged_segment_loader.sv
// rtl/staged_segment_loader.sv - staged segment loader with prescaled step timing
// Loads a shadowed input word into b one segment at a time, lowest segment first.
module staged_segment_loader #(
   parameter int DATA_W   = 100,
   parameter int SEGS     = 2,
   parameter int TICK_DIV = 4,
   parameter int CNT_W    = 16,
   parameter int FILL     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  step,
   input  logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [SEGS-1:0]   seg_valid,
   output logic              busy,
   output logic              done
);

   localparam int SEG_W = DATA_W / SEGS;
   localparam int IDX_W = (SEGS > 1) ? $clog2(SEGS) : 1;
   localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [SEG_W-1:0] FILL_SEG = SEG_W'(FILL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEGS - 1);
   localparam logic [PS_W-1:0]  PS_TOP   = PS_W'(TICK_DIV - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_next;
   logic [DATA_W-1:0] shadow;
   logic [CNT_W-1:0]  step_r;
   logic [CNT_W-1:0]  ivl;
   logic [CNT_W-1:0]  ivl_inc;
   logic [PS_W-1:0]   ps;
   logic [IDX_W-1:0]  idx;
   logic              tick;
   logic              accept;
   logic              load;
   logic              finish;
   logic              running;

   assign tick    = (ps == PS_TOP);
   assign ivl_inc = ivl + CNT_W'(1);
   assign busy    = (state == RUN);
   assign running = (state == RUN) && !abort;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // abort takes priority over both a pending start and a coincident segment load
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      load       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (tick && (ivl_inc == step_r)) begin
               load = 1'b1;
               if (idx == LAST_IDX) begin
                  finish     = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         b         <= '0;
         seg_valid <= '0;
         done      <= 1'b0;
         shadow    <= '0;
         step_r    <= '0;
         ps        <= '0;
         ivl       <= '0;
         idx       <= '0;
      end else begin
         done <= finish;
         if (accept) begin
            shadow    <= a;
            step_r    <= (step == '0) ? CNT_W'(1) : step;
            b         <= {SEGS{FILL_SEG}};
            seg_valid <= '0;
            ps        <= '0;
            ivl       <= '0;
            idx       <= '0;
         end else if (running) begin
            ps <= tick ? '0 : ps + PS_W'(1);
            if (load) begin
               ivl <= '0;
               idx <= idx + IDX_W'(1);
               for (int k = 0; k < SEGS; k++) begin
                  if (idx == IDX_W'(k)) begin
                     b[k*SEG_W +: SEG_W] <= shadow[k*SEG_W +: SEG_W];
                     seg_valid[k]        <= 1'b1;
                  end
               end
            end else if (tick) begin
               ivl <= ivl_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_staged_segment_loader.sv
// tb/tb_staged_segment_loader.sv - scoreboard bench for staged_segment_loader
// Expected load events are queued by the stimulus; monitors pop and compare on each new load or done.
module tb_staged_segment_loader;

   typedef struct {
      int          cyc;
      logic [99:0] b;
      logic [3:0]  sv;
      logic        busy;
      logic        done;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start0 = 1'b0, abort0 = 1'b0;
   logic [15:0] step0 = '0;
   logic [99:0] a0 = '0;
   logic [99:0] b0;
   logic [1:0]  sv0;
   logic        busy0, done0;

   logic        start1 = 1'b0, abort1 = 1'b0;
   logic [15:0] step1 = '0;
   logic [31:0] a1 = '0;
   logic [31:0] b1;
   logic [3:0]  sv1;
   logic        busy1, done1;

   int  cyc = 0;
   int  tests = 0;
   int  fails = 0;
   ev_t q0[$];
   ev_t q1[$];
   logic [1:0] prev0 = '0;
   logic [3:0] prev1 = '0;

   staged_segment_loader u0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0), .step(step0), .a(a0),
      .b(b0), .seg_valid(sv0), .busy(busy0), .done(done0)
   );

   staged_segment_loader #(.DATA_W(32), .SEGS(4), .TICK_DIV(1), .CNT_W(16), .FILL(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .step(step1), .a(a1),
      .b(b1), .seg_valid(sv1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int which, input int c, input logic [99:0] b,
                       input logic [3:0] sv, input logic busy, input logic done);
      ev_t e;
      e.cyc = c; e.b = b; e.sv = sv; e.busy = busy; e.done = done;
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
   endtask

   task automatic start_0(input logic [99:0] a, input logic [15:0] st, output int e0);
      @(negedge clk);
      a0 = a; step0 = st; start0 = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!rst) begin
         prev0 = '0;
      end else begin
         if (((sv0 & ~prev0) != '0) || done0) begin
            tests++;
            if (q0.size() == 0) begin
               fails++;
               $display("FAIL mon0 unexpected event cyc=%0d b=%h sv=%b busy=%b done=%b",
                        cyc, b0, sv0, busy0, done0);
            end else begin
               e = q0.pop_front();
               if (e.cyc != cyc || e.b !== b0 || e.sv !== {2'b00, sv0} || e.busy !== busy0 || e.done !== done0) begin
                  fails++;
                  $display("FAIL mon0 event got cyc=%0d b=%h sv=%b busy=%b done=%b need cyc=%0d b=%h sv=%b busy=%b done=%b",
                           cyc, b0, sv0, busy0, done0, e.cyc, e.b, e.sv[1:0], e.busy, e.done);
               end
            end
         end
         prev0 = sv0;
      end
   end

   always @(negedge clk) begin
      ev_t e;
      if (!rst) begin
         prev1 = '0;
      end else begin
         if (((sv1 & ~prev1) != '0) || done1) begin
            tests++;
            if (q1.size() == 0) begin
               fails++;
               $display("FAIL mon1 unexpected event cyc=%0d b=%h sv=%b busy=%b done=%b",
                        cyc, b1, sv1, busy1, done1);
            end else begin
               e = q1.pop_front();
               if (e.cyc != cyc || e.b[31:0] !== b1 || e.sv !== sv1 || e.busy !== busy1 || e.done !== done1) begin
                  fails++;
                  $display("FAIL mon1 event got cyc=%0d b=%h sv=%b busy=%b done=%b need cyc=%0d b=%h sv=%b busy=%b done=%b",
                           cyc, b1, sv1, busy1, done1, e.cyc, e.b[31:0], e.sv, e.busy, e.done);
               end
            end
         end
         prev1 = sv1;
      end
   end

   initial begin
      int          e0;
      logic [99:0] va;
      logic [99:0] fill_w;
      fill_w = {50'd1, 50'd1};

      // reset with no clock edge
      #1 rst = 1'b0;
      #1;
      check("reset_b0", b0, 0);
      check("reset_ctl0", {sv0, busy0, done0}, 0);
      check("reset_u1", {b1, sv1, busy1, done1}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // basic two-segment run, step=3
      va = 100'hF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
      start_0(va, 16'd3, e0);
      push(0, e0 + 12, {50'd1, va[49:0]}, 4'b0001, 1'b1, 1'b0);
      push(0, e0 + 24, va, 4'b0011, 1'b0, 1'b1);
      wait_to(e0 + 1);
      check("fill_b", b0, fill_w);
      check("fill_busy", {busy0, sv0}, 3'b100);
      wait_to(e0 + 25);
      check("done_clear", {busy0, done0}, 2'b00);

      // restart while busy ignored; a changes during run
      va = 100'h1_2345_6789_ABCD_EF01_2345_6789;
      start_0(va, 16'd3, e0);
      push(0, e0 + 12, {50'd1, va[49:0]}, 4'b0001, 1'b1, 1'b0);
      push(0, e0 + 24, va, 4'b0011, 1'b0, 1'b1);
      wait_to(e0 + 4);
      a0 = 100'hA_AAAA_5555_AAAA_5555_AAAA_5555; step0 = 16'd7; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      a0 = 100'h3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3;
      wait_to(e0 + 26);
      check("shadow_kept", b0, va);

      // abort mid-sequence
      va = 100'h9_8765_4321_0FED_CBA9_8765_4321;
      start_0(va, 16'd3, e0);
      push(0, e0 + 12, {50'd1, va[49:0]}, 4'b0001, 1'b1, 1'b0);
      wait_to(e0 + 14);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      check("abort_busy", busy0, 1'b0);
      check("abort_b", b0, {50'd1, va[49:0]});
      wait_to(e0 + 40);
      check("abort_hold", {b0, sv0, busy0}, {50'd1, va[49:0], 2'b01, 1'b0});

      // abort on the same edge as the final load
      va = 100'h1_2345_6789_ABCD_EF01_2345_6789;
      start_0(va, 16'd3, e0);
      push(0, e0 + 12, {50'd1, va[49:0]}, 4'b0001, 1'b1, 1'b0);
      wait_to(e0 + 23);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      check("abort_load", {b0, sv0, busy0}, {50'd1, va[49:0], 2'b01, 1'b0});
      wait_to(e0 + 30);

      // four byte segments, step=0, tick every cycle
      @(negedge clk);
      a1 = 32'hA1B2C3D4; step1 = 16'd0; start1 = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start1 = 1'b0;
      push(1, e0 + 1, {68'd0, 32'h010101D4}, 4'b0001, 1'b1, 1'b0);
      push(1, e0 + 2, {68'd0, 32'h0101C3D4}, 4'b0011, 1'b1, 1'b0);
      push(1, e0 + 3, {68'd0, 32'h01B2C3D4}, 4'b0111, 1'b1, 1'b0);
      push(1, e0 + 4, {68'd0, 32'hA1B2C3D4}, 4'b1111, 1'b0, 1'b1);
      wait_to(e0 + 6);
      check("u1_final", {b1, busy1, done1}, {32'hA1B2C3D4, 2'b00});

      // asynchronous reset mid-sequence
      va = 100'h9_8765_4321_0FED_CBA9_8765_4321;
      start_0(va, 16'd3, e0);
      push(0, e0 + 12, {50'd1, va[49:0]}, 4'b0001, 1'b1, 1'b0);
      wait_to(e0 + 13);
      #2 rst = 1'b0;
      #1;
      check("async_rst", {b0, sv0, busy0, done0}, 0);
      @(negedge clk);
      rst = 1'b1;
      wait_to(cyc + 30);
      check("post_rst_idle", {b0, sv0, busy0, done0}, 0);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
